// File: rtl/irq_encoder4_if.sv
// Request/acknowledge bundle between peripherals, consumer and irq_encoder4.
// The slave modport is the encoder's view; master is the environment's view.
interface irq_encoder4_if;
  logic [3:0] req;
  logic [3:0] mask;
  logic       ack;
  logic       irq;
  logic [1:0] vec;
  logic [3:0] pend;
  logic [3:0] ovf;

  modport slave (
    input  req,
    input  mask,
    input  ack,
    output irq,
    output vec,
    output pend,
    output ovf
  );

  modport master (
    output req,
    output mask,
    output ack,
    input  irq,
    input  vec,
    input  pend,
    input  ovf
  );
endinterface

// File: rtl/irq_encoder4.sv
// Four-source edge-triggered interrupt encoder: latches request edges, flags overruns,
// and presents the highest-priority unmasked pending source to a consumer with ack handshake.
module irq_encoder4 (
  input logic           clk,
  input logic           rst_n,
  irq_encoder4_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAssert = 2'd1,
    StHold   = 2'd2
  } state_e;

  state_e     state_q;
  logic [3:0] req_q;
  logic [3:0] pend_q, pend_d;
  logic [3:0] ovf_q, ovf_d;
  logic       irq_q;
  logic [1:0] vec_q;

  logic [3:0] rise;
  logic [3:0] clr;
  logic [3:0] elig;
  logic [1:0] enc;
  logic       serviced;

  always_comb begin
    rise     = bus.req & ~req_q;
    serviced = (state_q == StAssert) && bus.ack;
    clr      = 4'b0000;
    if (serviced) begin
      clr[vec_q] = 1'b1;
    end

    // A new edge always wins over a same-cycle clear.
    pend_d = rise | (pend_q & ~clr);

    ovf_d = ovf_q;
    for (int i = 0; i < 4; i++) begin
      if (clr[i] && rise[i]) begin
        ovf_d[i] = ovf_q[i];
      end else if (clr[i]) begin
        ovf_d[i] = 1'b0;
      end else begin
        ovf_d[i] = ovf_q[i] | (rise[i] & pend_q[i]);
      end
    end

    elig = pend_q & ~bus.mask;
    enc  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (elig[i]) begin
        enc = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      req_q   <= 4'b0000;
      pend_q  <= 4'b0000;
      ovf_q   <= 4'b0000;
      irq_q   <= 1'b0;
      vec_q   <= 2'b00;
    end else begin
      req_q  <= bus.req;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      case (state_q)
        StIdle: begin
          if (|elig) begin
            state_q <= StAssert;
            irq_q   <= 1'b1;
            vec_q   <= enc;
          end
        end
        // vec stays frozen here; masking does not withdraw the request.
        StAssert: begin
          if (bus.ack) begin
            state_q <= StHold;
            irq_q   <= 1'b0;
          end
        end
        StHold: begin
          state_q <= StIdle;
          irq_q   <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq  = irq_q;
  assign bus.vec  = vec_q;
  assign bus.pend = pend_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_irq_encoder4.sv
// Directed table-driven bench for irq_encoder4: each record applies inputs for one clock
// and lists the outputs expected just after that edge.
module tb_irq_encoder4;

  logic clk;
  logic rst_n;

  irq_encoder4_if bus ();

  irq_encoder4 u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack;
    logic       irq;
    logic [1:0] vec;
    logic [3:0] pend;
    logic [3:0] ovf;
  } vec_t;

  vec_t tbl[$];
  int   n_pass;
  int   n_total;

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] mk, input logic ak,
                     input logic ei, input logic [1:0] ev, input logic [3:0] ep,
                     input logic [3:0] eo);
    vec_t v;
    v.rst_n = r;
    v.req   = rq;
    v.mask  = mk;
    v.ack   = ak;
    v.irq   = ei;
    v.vec   = ev;
    v.pend  = ep;
    v.ovf   = eo;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] got,
                       input logic [3:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s step %0d: got %b, expected %b", name, idx, got, exp);
    end
  endtask

  task automatic run(input string tag, input int idx, input vec_t v);
    rst_n    = v.rst_n;
    bus.req  = v.req;
    bus.mask = v.mask;
    bus.ack  = v.ack;
    @(posedge clk);
    #1;
    check({tag, ".irq"}, idx, {3'b000, bus.irq}, {3'b000, v.irq});
    check({tag, ".vec"}, idx, {2'b00, bus.vec}, {2'b00, v.vec});
    check({tag, ".pend"}, idx, bus.pend, v.pend);
    check({tag, ".ovf"}, idx, bus.ovf, v.ovf);
  endtask

  task automatic seq(input string tag, input int idx, input logic r, input logic [3:0] rq,
                     input logic [3:0] mk, input logic ak, input logic ei, input logic [1:0] ev,
                     input logic [3:0] ep, input logic [3:0] eo);
    vec_t v;
    v.rst_n = r;
    v.req   = rq;
    v.mask  = mk;
    v.ack   = ak;
    v.irq   = ei;
    v.vec   = ev;
    v.pend  = ep;
    v.ovf   = eo;
    run(tag, idx, v);
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.mask = 4'b0000;
    bus.ack  = 1'b0;

    //  rst  req      mask     ack   irq   vec    pend     ovf
    // reset
    add(0, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'b0000);
    // single event, latency and ack
    add(1, 4'b0001, 4'b0000, 0, 0, 2'd0, 4'b0001, 4'b0000);
    add(1, 4'b0001, 4'b0000, 0, 1, 2'd0, 4'b0001, 4'b0000);
    add(1, 4'b0001, 4'b0000, 0, 1, 2'd0, 4'b0001, 4'b0000);
    add(1, 4'b0000, 4'b0000, 1, 0, 2'd0, 4'b0000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'b0000);
    // priority 1010: vec 1 first, then vec 3 after HOLD+IDLE
    add(1, 4'b1010, 4'b0000, 0, 0, 2'd0, 4'b1010, 4'b0000);
    add(1, 4'b1010, 4'b0000, 0, 1, 2'd1, 4'b1010, 4'b0000);
    add(1, 4'b1010, 4'b0000, 1, 0, 2'd1, 4'b1000, 4'b0000);
    add(1, 4'b1010, 4'b0000, 0, 0, 2'd1, 4'b1000, 4'b0000);
    add(1, 4'b1010, 4'b0000, 0, 1, 2'd3, 4'b1000, 4'b0000);
    add(1, 4'b1010, 4'b0000, 1, 0, 2'd3, 4'b0000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 2'd3, 4'b0000, 4'b0000);
    // masked source latches but does not raise irq until unmasked
    add(1, 4'b0001, 4'b0001, 0, 0, 2'd3, 4'b0001, 4'b0000);
    add(1, 4'b0001, 4'b0001, 0, 0, 2'd3, 4'b0001, 4'b0000);
    add(1, 4'b0001, 4'b0001, 0, 0, 2'd3, 4'b0001, 4'b0000);
    add(1, 4'b0001, 4'b0000, 0, 1, 2'd0, 4'b0001, 4'b0000);
    // masking during ASSERT keeps irq
    add(1, 4'b0001, 4'b1111, 0, 1, 2'd0, 4'b0001, 4'b0000);
    add(1, 4'b0000, 4'b1111, 1, 0, 2'd0, 4'b0000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'b0000);
    // overrun on source 2, cleared by its ack
    add(1, 4'b0100, 4'b0000, 0, 0, 2'd0, 4'b0100, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 1, 2'd2, 4'b0100, 4'b0000);
    add(1, 4'b0100, 4'b0000, 0, 1, 2'd2, 4'b0100, 4'b0100);
    add(1, 4'b0000, 4'b0000, 0, 1, 2'd2, 4'b0100, 4'b0100);
    add(1, 4'b0000, 4'b0000, 1, 0, 2'd2, 4'b0000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 0, 2'd2, 4'b0000, 4'b0000);
    // new edge on source 0 in the same cycle as its ack: set wins
    add(1, 4'b0001, 4'b0000, 0, 0, 2'd2, 4'b0001, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0, 1, 2'd0, 4'b0001, 4'b0000);
    add(1, 4'b0001, 4'b0000, 1, 0, 2'd0, 4'b0001, 4'b0000);
    add(1, 4'b0001, 4'b0000, 0, 0, 2'd0, 4'b0001, 4'b0000);
    add(1, 4'b0001, 4'b0000, 0, 1, 2'd0, 4'b0001, 4'b0000);
    // ack ignored in HOLD and IDLE
    add(1, 4'b0000, 4'b0000, 1, 0, 2'd0, 4'b0000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 1, 0, 2'd0, 4'b0000, 4'b0000);
    add(1, 4'b0000, 4'b0000, 1, 0, 2'd0, 4'b0000, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      run("tbl", i, tbl[i]);
    end

    // reset mid-ASSERT with pend=0110 and an overrun, then a spurious ack
    seq("rst_mid", 0, 1, 4'b0110, 4'b0000, 0, 0, 2'd0, 4'b0110, 4'b0000);
    seq("rst_mid", 1, 1, 4'b0000, 4'b0000, 0, 1, 2'd1, 4'b0110, 4'b0000);
    seq("rst_mid", 2, 1, 4'b0010, 4'b0000, 0, 1, 2'd1, 4'b0110, 4'b0010);
    seq("rst_mid", 3, 0, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'b0000);
    seq("rst_mid", 4, 1, 4'b0000, 4'b0000, 1, 0, 2'd0, 4'b0000, 4'b0000);
    seq("rst_mid", 5, 1, 4'b0000, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'b0000);

    // req held high through reset counts as a rise on the first active cycle
    seq("rst_hi", 0, 0, 4'b1000, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'b0000);
    seq("rst_hi", 1, 0, 4'b1000, 4'b0000, 0, 0, 2'd0, 4'b0000, 4'b0000);
    seq("rst_hi", 2, 1, 4'b1000, 4'b0000, 0, 0, 2'd0, 4'b1000, 4'b0000);
    seq("rst_hi", 3, 1, 4'b1000, 4'b0000, 0, 1, 2'd3, 4'b1000, 4'b0000);
    seq("rst_hi", 4, 1, 4'b0000, 4'b0000, 1, 0, 2'd3, 4'b0000, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
